// File: rtl/rom_reader.sv
// Burst reader for a synchronous ROM: issues reads ahead under a 3-entry credit
// and streams the returned words out through a valid/ready port.
module rom_reader #(
    parameter int  DATA_SIZE  = 1,
    parameter int  ADDR_WIDTH = 8,
    localparam int DATA_WIDTH = 8 * DATA_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_issue_rem, r_deliv_rem;
    logic                  r_pending, r_done;
    logic [DATA_WIDTH-1:0] r_fifo [3];
    logic [1:0]            r_wptr, r_rptr, r_fcnt;

    logic w_start_ok, w_start_zero, w_credit, w_issue, w_pop, w_last_pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign w_start_ok   = (r_state == IDLE) && start && (count != '0);
    assign w_start_zero = (r_state == IDLE) && start && (count == '0);
    // Words in flight plus words buffered must fit the FIFO, so it never overflows.
    assign w_credit     = ({1'b0, r_fcnt} + {2'b0, r_pending}) < 3'd3;
    assign w_issue      = (r_state == FETCH) && (r_issue_rem != '0) && w_credit;
    assign w_pop        = out_valid && out_ready;
    assign w_last_pop   = w_pop && out_last;

    assign rom_addr  = r_addr;
    assign out_valid = (r_fcnt != 2'd0);
    assign out_data  = r_fifo[r_rptr];
    assign out_last  = out_valid && (r_deliv_rem == (ADDR_WIDTH+1)'(1));
    assign busy      = (r_state != IDLE);
    assign done      = r_done;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (w_start_ok) w_state_nxt = FETCH;
            FETCH: begin
                if (w_last_pop)
                    w_state_nxt = IDLE;
                else if (w_issue && r_issue_rem == (ADDR_WIDTH+1)'(1))
                    w_state_nxt = DRAIN;
            end
            DRAIN: if (w_last_pop) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_issue_rem <= '0;
            r_deliv_rem <= '0;
            r_pending   <= 1'b0;
            r_done      <= 1'b0;
            r_wptr      <= 2'd0;
            r_rptr      <= 2'd0;
            r_fcnt      <= 2'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= w_start_zero || w_last_pop;
            r_pending <= w_issue;
            if (w_start_ok) begin
                r_addr      <= start_addr;
                r_issue_rem <= count;
                r_deliv_rem <= count;
            end else begin
                if (w_issue) begin
                    r_addr      <= r_addr + ADDR_WIDTH'(1);
                    r_issue_rem <= r_issue_rem - (ADDR_WIDTH+1)'(1);
                end
                if (w_pop)
                    r_deliv_rem <= r_deliv_rem - (ADDR_WIDTH+1)'(1);
            end
            if (r_pending) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)     r_rptr <= ptr_inc(r_rptr);
            case ({r_pending, w_pop})
                2'b10:   r_fcnt <= r_fcnt + 2'd1;
                2'b01:   r_fcnt <= r_fcnt - 2'd1;
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by r_fcnt.
    always_ff @(posedge clk) begin
        if (r_pending) r_fifo[r_wptr] <= rom_data;
    end

endmodule

// File: tb/tb_rom_reader.sv
// Directed bench for rom_reader against a synchronous ROM model with rom[i] = i + 0x10.
module tb_rom_reader;

    logic       clk = 1'b0;
    logic       rst, start, out_ready;
    logic [7:0] start_addr, rom_addr, rom_data, out_data;
    logic [8:0] count;
    logic       out_valid, out_last, busy, done;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    logic [7:0] got [$];

    rom_reader #(.DATA_SIZE(1), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .count(count), .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_addr + 8'h10;

    // Record transfers and done pulses mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) got.push_back(out_data);
        if (done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int max);
        int i;
        i = 0;
        while (!done && i < max) begin
            step();
            i++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic chk_got(input string tag, input logic [7:0] first, input int n);
        chk({tag, "_n"}, got.size(), n);
        for (int k = 0; k < n && k < got.size(); k++)
            chk(tag, {24'd0, got[k]}, {24'd0, first + 8'(k)});
    endtask

    task automatic go(input logic [7:0] a, input logic [8:0] c);
        start_addr = a;
        count      = c;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    task automatic basic_burst(input string tag);
        got.delete();
        done_cnt = 0;
        go(8'h04, 9'd3);                                   // now t1
        chk({tag, "_t1_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_t1_addr"}, {24'd0, rom_addr}, 32'h04);
        step();                                            // t2
        chk({tag, "_t2_vld"}, {31'd0, out_valid}, 32'd0);
        step();                                            // t3
        chk({tag, "_t3_vld"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_t3_data"}, {24'd0, out_data}, 32'h14);
        chk({tag, "_t3_last"}, {31'd0, out_last}, 32'd0);
        step();                                            // t4
        chk({tag, "_t4_data"}, {24'd0, out_data}, 32'h15);
        step();                                            // t5
        chk({tag, "_t5_data"}, {24'd0, out_data}, 32'h16);
        chk({tag, "_t5_last"}, {31'd0, out_last}, 32'd1);
        step();                                            // t6
        chk({tag, "_t6_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_t6_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_t6_vld"}, {31'd0, out_valid}, 32'd0);
        step();
        chk({tag, "_t7_done"}, {31'd0, done}, 32'd0);
        chk_got(tag, 8'h14, 3);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_addr = '0; count = '0; out_ready = 1'b1;
        step(); step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_vld", {31'd0, out_valid}, 32'd0);
        chk("rst_last", {31'd0, out_last}, 32'd0);
        chk("rst_addr", {24'd0, rom_addr}, 32'd0);
        rst = 1'b0;
        step();

        basic_burst("b1");

        // Zero-length request
        got.delete(); done_cnt = 0;
        go(8'h33, 9'd0);
        chk("z_done", {31'd0, done}, 32'd1);
        chk("z_busy", {31'd0, busy}, 32'd0);
        chk("z_vld", {31'd0, out_valid}, 32'd0);
        step();
        chk("z_done2", {31'd0, done}, 32'd0);
        chk("z_vld2", {31'd0, out_valid}, 32'd0);
        chk("z_got", got.size(), 0);

        // Address wrap
        got.delete(); done_cnt = 0;
        go(8'hFE, 9'd4);
        chk("w_a0", {24'd0, rom_addr}, 32'hFE);
        step();
        chk("w_a1", {24'd0, rom_addr}, 32'hFF);
        step();
        chk("w_a2", {24'd0, rom_addr}, 32'h00);
        step();
        chk("w_a3", {24'd0, rom_addr}, 32'h01);
        wait_done("w_done", 20);
        chk_got("w", 8'h0E, 4);
        step();

        // Backpressure, plus an ignored start while busy
        got.delete(); done_cnt = 0;
        out_ready = 1'b0;
        go(8'h04, 9'd5);                                   // t1
        step();                                            // t2
        start_addr = 8'h80; count = 9'd2; start = 1'b1;
        step();                                            // t3
        start = 1'b0;
        chk("s_t3_data", {24'd0, out_data}, 32'h14);
        for (int i = 0; i < 8; i++) step();                // t11
        chk("s_vld", {31'd0, out_valid}, 32'd1);
        chk("s_hold", {24'd0, out_data}, 32'h14);
        chk("s_issued", {24'd0, rom_addr}, 32'h07);
        chk("s_busy", {31'd0, busy}, 32'd1);
        chk("s_none", got.size(), 0);
        out_ready = 1'b1;
        wait_done("s_done", 20);
        step();
        chk_got("s", 8'h14, 5);
        chk("s_done_cnt", done_cnt, 1);
        chk("s_end_addr", {24'd0, rom_addr}, 32'h09);

        // Reset mid-burst
        got.delete(); done_cnt = 0;
        go(8'h04, 9'd8);                                   // t1
        step(); step(); step(); step();                    // t5: two words taken
        rst = 1'b1;
        step();
        chk("r_vld", {31'd0, out_valid}, 32'd0);
        chk("r_busy", {31'd0, busy}, 32'd0);
        chk("r_last", {31'd0, out_last}, 32'd0);
        chk("r_addr", {24'd0, rom_addr}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("r_vld2", {31'd0, out_valid}, 32'd0);
        chk("r_nodone", done_cnt, 0);
        chk_got("r", 8'h14, 2);

        basic_burst("b2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rom_reader.md
ROM_READER -- requirements
Module: rom_reader

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 1, word size in bytes; DATA_WIDTH = 8*DATA_SIZE (derived, not overridable).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, ROM address width.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst read.
REQ-006 SHALL have port start_addr  input  ADDR_WIDTH  first word address of burst.
REQ-007 SHALL have port count  input  ADDR_WIDTH+1  number of words in burst (0..2^ADDR_WIDTH).
REQ-008 SHALL have port rom_addr  output  ADDR_WIDTH  address driven to synchronous ROM.
REQ-009 SHALL have port rom_data  input  DATA_WIDTH  ROM read data, valid the cycle after rom_addr is presented.
REQ-010 SHALL have port out_valid  output  1  stream word valid.
REQ-011 SHALL have port out_ready  input  1  stream consumer ready.
REQ-012 SHALL have port out_data  output  DATA_WIDTH  stream word.
REQ-013 SHALL have port out_last  output  1  marks final word of burst, qualified by out_valid.
REQ-014 SHALL have port busy  output  1  burst in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse when burst completes.

Function
REQ-016 SHALL implement states IDLE, FETCH, DRAIN; busy = 1 in FETCH and DRAIN only.
REQ-017 In IDLE, start=1 with count>0 SHALL load address register with start_addr, remaining-issue counter with count, remaining-deliver counter with count, and move to FETCH.
REQ-018 In IDLE, start=1 with count=0 SHALL emit done=1 on the next cycle, stay IDLE, issue no reads, emit no words.
REQ-019 start while busy=1 SHALL be ignored with no effect on the running burst.
REQ-020 A read is issued in a cycle when state is FETCH, remaining-issue > 0, and fifo_count + pending < 3; rom_addr SHALL equal the address register at all times.
REQ-021 On issue, address register SHALL increment by 1 modulo 2^ADDR_WIDTH (0xFF wraps to 0x00 for ADDR_WIDTH=8) and remaining-issue SHALL decrement.
REQ-022 pending (0 or 1) SHALL be 1 in the cycle after an issue; rom_data in that cycle SHALL be written into a 3-entry FIFO at its end.
REQ-023 FIFO SHALL never overflow; credit rule of REQ-020 guarantees space; no pop credit is taken.
REQ-024 out_valid = FIFO non-empty; out_data = FIFO head; a word transfers when out_valid & out_ready, popping the head.
REQ-025 Simultaneous FIFO write and pop SHALL keep fifo_count unchanged and preserve order.
REQ-026 out_valid/out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-027 out_last SHALL be 1 exactly when the head is the final word of the burst (remaining-deliver = 1).
REQ-028 When remaining-issue reaches 0, state SHALL move FETCH->DRAIN.
REQ-029 Transfer of the out_last word SHALL move state to IDLE, with done=1 in the following cycle.
REQ-030 With out_ready held 1, words SHALL arrive at one per cycle; first out_valid 3 cycles after the start cycle (start at t0, issue t1, capture t2, out_valid t3).
REQ-031 count = 2^ADDR_WIDTH SHALL read every address once, wrapping, and deliver exactly 2^ADDR_WIDTH words.
REQ-032 A new start SHALL be accepted in the cycle done=1 (state is IDLE).

Reset
REQ-033 rst=1 SHALL, at the clock edge, force state IDLE, busy=0, done=0, out_valid=0, out_last=0, FIFO empty, pending=0, address register and rom_addr=0, counters=0; out_data is don't-care while out_valid=0.
REQ-034 rst mid-burst SHALL discard all FIFO contents and pending data with no done pulse; rom_data returned after reset SHALL be ignored.

Verification
REQ-035 ROM preloaded with rom[i]=i+0x10; start_addr=0x04, count=3, out_ready=1 -> out_data 0x14,0x15,0x16 in cycles t3..t5, out_last at 0x16, done at t6.
REQ-036 start_addr=0xFE, count=4 -> rom_addr sequence 0xFE,0xFF,0x00,0x01; data 0x0E,0x0F,0x10,0x11 in order.
REQ-037 count=5, out_ready=0 for 10 cycles then 1 -> at most 3 reads issued, out_data held at 0x14 during stall, all 5 words delivered in order, no drop/duplicate.
REQ-038 count=0 -> done one cycle later, out_valid never asserts, busy stays 0.
REQ-039 rst asserted for one cycle after 2nd word of an 8-word burst -> all outputs at reset values next cycle, no further words, no done; fresh start afterwards behaves as REQ-035.
REQ-040 start pulsed during busy with different start_addr -> ignored, original burst completes unchanged.
